// File: rtl/conv_pkg.sv
// Shared types and default constants for the convolution sequencer.
package conv_pkg;

    // Sequencer phases: kernel load, image streaming, systolic flush, completion.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_K = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Default geometry and timing of the target tile.
    localparam int DEF_ROW_LEN   = 16;
    localparam int DEF_NUM_ROWS  = 8;
    localparam int DEF_KER_ROWS  = 3;
    localparam int DEF_BRAM_LAT  = 1;
    localparam int DEF_DRAIN_CYC = 8;

    // Width of a counter that must hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/valid_pipe.sv
// Shift-register delay line that aligns control tags with BRAM read data.
// Bit 0 of each stage is the valid flag; other bits ride along with it.
module valid_pipe #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic             pend_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Shift one stage per enabled cycle; clear wipes every stage at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q <= '0;
        end else if (clr_i) begin
            stage_q <= '0;
        end else if (en_i) begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

    // A valid still travelling in any stage ahead of the output stage.
    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            pend_o = pend_o | stage_q[i][0];
        end
    end

endmodule

// File: rtl/conv_sequencer.sv
// Frame sequencer for the convolution tile: loads kernel rows, streams the
// image banks linearly, flushes the systolic array and signals completion.
// run_en=0 freezes everything and masks every enable/pulse output; abort
// returns to IDLE from any busy state without a completion pulse.
module conv_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_ADDR_W = 14,
    parameter int KER_ADDR_W = 2,
    parameter int ROW_LEN    = DEF_ROW_LEN,
    parameter int NUM_ROWS   = DEF_NUM_ROWS,
    parameter int KER_ROWS   = DEF_KER_ROWS,
    parameter int BRAM_LAT   = DEF_BRAM_LAT,
    parameter int DRAIN_CYC  = DEF_DRAIN_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  run_en,
    input  logic                  abort,
    output logic                  ker_en,
    output logic [KER_ADDR_W-1:0] ker_addr,
    output logic                  img_en,
    output logic [IMG_ADDR_W-1:0] img_addr,
    output logic                  data_valid,
    output logic                  is_row_done,
    output logic                  is_compute_done,
    output logic                  busy
);

    localparam int COL_W = cnt_w(ROW_LEN);
    localparam int ROW_W = cnt_w(NUM_ROWS);
    localparam int DRN_W = cnt_w(DRAIN_CYC);

    localparam logic [KER_ADDR_W-1:0] KER_FIRST = KER_ADDR_W'(1);
    localparam logic [KER_ADDR_W-1:0] KER_LAST  = KER_ADDR_W'(KER_ROWS);
    localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(ROW_LEN - 1);
    localparam logic [ROW_W-1:0]      ROW_LAST  = ROW_W'(NUM_ROWS - 1);
    localparam logic [DRN_W-1:0]      DRN_LAST  = DRN_W'(DRAIN_CYC - 1);

    // Parameter sanity, caught at elaboration.
    if (KER_ROWS < 1 || KER_ROWS >= (1 << KER_ADDR_W)) begin : g_bad_ker_rows
        $error("conv_sequencer: KER_ROWS must lie in 1 .. 2**KER_ADDR_W-1");
    end
    if ((64'(ROW_LEN) * 64'(NUM_ROWS)) > (64'd1 << IMG_ADDR_W)) begin : g_bad_img_size
        $error("conv_sequencer: ROW_LEN*NUM_ROWS does not fit in IMG_ADDR_W");
    end
    if (BRAM_LAT < 1 || BRAM_LAT > 3) begin : g_bad_lat
        $error("conv_sequencer: BRAM_LAT must lie in 1 .. 3");
    end
    if (ROW_LEN < 1 || NUM_ROWS < 1 || DRAIN_CYC < 1) begin : g_bad_geom
        $error("conv_sequencer: ROW_LEN, NUM_ROWS and DRAIN_CYC must be at least 1");
    end

    state_t                  state_q;
    logic                    ker_en_q;
    logic [KER_ADDR_W-1:0]   ker_addr_q;
    logic                    img_en_q;
    logic [IMG_ADDR_W-1:0]   img_addr_q;
    logic [COL_W-1:0]        col_q;
    logic [ROW_W-1:0]        row_q;
    logic [DRN_W-1:0]        drain_q;
    logic                    done_q;

    logic                    abort_hit;
    logic [1:0]              pipe_d;
    logic [1:0]              pipe_q;
    logic                    pipe_pend;

    // An abort only matters while a frame is in flight.
    assign abort_hit = abort && (state_q != ST_IDLE);

    // Tag each issued image read: bit 0 valid, bit 1 last column of its row.
    assign pipe_d = {img_en_q && (col_q == COL_LAST), img_en_q};

    valid_pipe #(
        .DEPTH (BRAM_LAT),
        .WIDTH (2)
    ) u_valid_pipe (
        .clk_i  (clk),
        .rst_i  (rst),
        .en_i   (run_en),
        .clr_i  (abort_hit),
        .d_i    (pipe_d),
        .q_o    (pipe_q),
        .pend_o (pipe_pend)
    );

    // Main sequencer: state, address/col/row/drain counters and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ker_en_q   <= 1'b0;
            ker_addr_q <= '0;
            img_en_q   <= 1'b0;
            img_addr_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            done_q     <= 1'b0;
        end else if (abort_hit) begin
            // Abandon the frame; the next start begins again from address 0.
            state_q    <= ST_IDLE;
            ker_en_q   <= 1'b0;
            ker_addr_q <= '0;
            img_en_q   <= 1'b0;
            img_addr_q <= '0;
            col_q      <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            done_q     <= 1'b0;
        end else if (run_en) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q    <= ST_LOAD_K;
                        ker_en_q   <= 1'b1;
                        ker_addr_q <= KER_FIRST;
                    end
                end

                ST_LOAD_K: begin
                    if (ker_addr_q == KER_LAST) begin
                        state_q    <= ST_STREAM;
                        ker_en_q   <= 1'b0;
                        ker_addr_q <= '0;
                        img_en_q   <= 1'b1;
                        img_addr_q <= '0;
                        col_q      <= '0;
                        row_q      <= '0;
                    end else begin
                        ker_addr_q <= ker_addr_q + 1'b1;
                    end
                end

                ST_STREAM: begin
                    if (col_q == COL_LAST) begin
                        col_q <= '0;
                        if (row_q == ROW_LAST) begin
                            // Last image word issued; stop before the address can wrap.
                            state_q    <= ST_DRAIN;
                            img_en_q   <= 1'b0;
                            img_addr_q <= '0;
                            row_q      <= '0;
                            drain_q    <= '0;
                        end else begin
                            row_q      <= row_q + 1'b1;
                            img_addr_q <= img_addr_q + 1'b1;
                        end
                    end else begin
                        col_q      <= col_q + 1'b1;
                        img_addr_q <= img_addr_q + 1'b1;
                    end
                end

                ST_DRAIN: begin
                    // Flush count runs once no read is still ahead of the output stage.
                    if (!pipe_pend) begin
                        if (drain_q == DRN_LAST) begin
                            state_q <= ST_DONE;
                            drain_q <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            drain_q <= drain_q + 1'b1;
                        end
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Enables and pulses are masked during a stall; addresses simply hold.
    assign ker_en          = ker_en_q && run_en;
    assign ker_addr        = ker_addr_q;
    assign img_en          = img_en_q && run_en;
    assign img_addr        = img_addr_q;
    assign data_valid      = pipe_q[0] && run_en;
    assign is_row_done     = pipe_q[1] && run_en;
    assign is_compute_done = done_q && run_en;
    assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer: one DUT with BRAM_LAT=1 and one with
// BRAM_LAT=3 share all inputs; a selector picks which one is observed.
module tb_conv_sequencer;

  localparam int IMG_ADDR_W = 14;
  localparam int KER_ADDR_W = 2;
  localparam int ROW_LEN    = 4;
  localparam int NUM_ROWS   = 2;
  localparam int KER_ROWS   = 3;
  localparam int DRAIN_CYC  = 8;
  localparam int STALL_LEN  = 5;

  // ---------------- clock / reset / inputs ----------------
  logic clk = 1'b0;
  logic rst, start, run_en, abort;

  always #5 clk = ~clk;

  logic                  a_ker_en, a_img_en, a_dv, a_rd, a_cd, a_busy;
  logic [KER_ADDR_W-1:0] a_ker_addr;
  logic [IMG_ADDR_W-1:0] a_img_addr;
  logic                  b_ker_en, b_img_en, b_dv, b_rd, b_cd, b_busy;
  logic [KER_ADDR_W-1:0] b_ker_addr;
  logic [IMG_ADDR_W-1:0] b_img_addr;

  conv_sequencer #(
    .IMG_ADDR_W(IMG_ADDR_W), .KER_ADDR_W(KER_ADDR_W), .ROW_LEN(ROW_LEN),
    .NUM_ROWS(NUM_ROWS), .KER_ROWS(KER_ROWS), .BRAM_LAT(1), .DRAIN_CYC(DRAIN_CYC)
  ) u_dut_lat1 (
    .clk(clk), .rst(rst), .start(start), .run_en(run_en), .abort(abort),
    .ker_en(a_ker_en), .ker_addr(a_ker_addr), .img_en(a_img_en), .img_addr(a_img_addr),
    .data_valid(a_dv), .is_row_done(a_rd), .is_compute_done(a_cd), .busy(a_busy)
  );

  conv_sequencer #(
    .IMG_ADDR_W(IMG_ADDR_W), .KER_ADDR_W(KER_ADDR_W), .ROW_LEN(ROW_LEN),
    .NUM_ROWS(NUM_ROWS), .KER_ROWS(KER_ROWS), .BRAM_LAT(3), .DRAIN_CYC(DRAIN_CYC)
  ) u_dut_lat3 (
    .clk(clk), .rst(rst), .start(start), .run_en(run_en), .abort(abort),
    .ker_en(b_ker_en), .ker_addr(b_ker_addr), .img_en(b_img_en), .img_addr(b_img_addr),
    .data_valid(b_dv), .is_row_done(b_rd), .is_compute_done(b_cd), .busy(b_busy)
  );

  // Observed view: sel=0 -> BRAM_LAT=1 instance, sel=1 -> BRAM_LAT=3 instance.
  logic                  sel;
  logic                  o_ker_en, o_img_en, o_dv, o_rd, o_cd, o_busy;
  logic [KER_ADDR_W-1:0] o_ker_addr;
  logic [IMG_ADDR_W-1:0] o_img_addr;

  always_comb begin
    o_ker_en   = sel ? b_ker_en   : a_ker_en;
    o_ker_addr = sel ? b_ker_addr : a_ker_addr;
    o_img_en   = sel ? b_img_en   : a_img_en;
    o_img_addr = sel ? b_img_addr : a_img_addr;
    o_dv       = sel ? b_dv       : a_dv;
    o_rd       = sel ? b_rd       : a_rd;
    o_cd       = sel ? b_cd       : a_cd;
    o_busy     = sel ? b_busy     : a_busy;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] ker_q[$];
  logic [31:0] img_q[$];
  int          img_cyc[$];
  int          dv_cyc[$];
  int          rd_idx[$];
  int          busy_cnt, cd_cnt, dv_n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [31:0] outs_all();
    return {10'd0, o_ker_en, o_ker_addr, o_img_en, o_img_addr, o_dv, o_rd, o_cd, o_busy};
  endfunction

  // ---------------- driver tasks ----------------
  // Pulses start, then observes the selected DUT cycle by cycle until busy
  // falls. Each *_addr argument (-1 = unused) fires its action in the cycle
  // where img_en is seen with that address.
  task automatic run_frame(input logic s, input int stall_addr, input int abort_addr,
                           input int start_addr, input int rst_addr);
    int  stall_left;
    bit  stall_done, abort_done, start_done, rst_done, seen_busy, fin, check_idle;
    stall_left = 0;
    stall_done = 0; abort_done = 0; start_done = 0; rst_done = 0;
    seen_busy = 0; fin = 0; check_idle = 0;
    sel = s;
    ker_q.delete(); img_q.delete(); img_cyc.delete(); dv_cyc.delete(); rd_idx.delete();
    busy_cnt = 0; cd_cnt = 0; dv_n = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
      start = 1'b0;
      abort = 1'b0;
      rst   = 1'b0;
      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) run_en = 1'b1;
      end
      #1;
      if (!stall_done && stall_addr >= 0 && o_img_en && o_img_addr == IMG_ADDR_W'(stall_addr)) begin
        run_en = 1'b0;
        stall_left = STALL_LEN;
        stall_done = 1;
      end
      if (!abort_done && abort_addr >= 0 && o_img_en && o_img_addr == IMG_ADDR_W'(abort_addr)) begin
        abort = 1'b1;
        abort_done = 1;
      end
      if (!start_done && start_addr >= 0 && o_img_en && o_img_addr == IMG_ADDR_W'(start_addr)) begin
        start = 1'b1;
        start_done = 1;
      end
      if (!rst_done && rst_addr >= 0 && o_img_en && o_img_addr == IMG_ADDR_W'(rst_addr)) begin
        rst = 1'b1;
        rst_done = 1;
        #1;
        chk("rst_async_outputs_zero", outs_all(), 32'd0);
      end
      #1;
      if (check_idle) begin
        chk("abort_next_cycle_outputs_zero", outs_all(), 32'd0);
        check_idle = 0;
      end
      if (abort) check_idle = 1;
      if (!run_en) begin
        chk("stall_img_addr_held", 32'(o_img_addr), 32'(stall_addr));
        chk("stall_img_en_low", 32'(o_img_en), 32'd0);
        chk("stall_data_valid_low", 32'(o_dv), 32'd0);
      end
      if (o_busy) begin
        busy_cnt++;
        seen_busy = 1;
      end
      if (o_ker_en) ker_q.push_back(32'(o_ker_addr));
      if (o_img_en) begin
        img_q.push_back(32'(o_img_addr));
        img_cyc.push_back(cyc);
      end
      if (o_dv) begin
        dv_cyc.push_back(cyc);
        if (o_rd) rd_idx.push_back(dv_n);
        dv_n++;
      end else if (o_rd) begin
        rd_idx.push_back(-1);
      end
      if (o_cd) cd_cnt++;
      if (seen_busy && !o_busy) fin = 1;
      if (!fin) @(negedge clk);
    end
    chk("frame_ended_in_budget", 32'(fin), 32'd1);
  endtask

  // Releases all inputs and checks the observed outputs stay quiet.
  task automatic idle_check(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0; start = 1'b0; abort = 1'b0; run_en = 1'b1;
      #1;
      chk(tag, outs_all(), 32'd0);
    end
  endtask

  // Compares the recorded frame against hand-computed expectations.
  task automatic chk_frame(input string tag, input int n_img, input int lat,
                           input int busy_exp, input int cd_exp, input int n_rd);
    int exp_rd[2];
    exp_rd = '{3, 7};
    chk({tag, "_ker_count"}, 32'(ker_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_ker_addr%0d", tag, i), (i < ker_q.size()) ? ker_q[i] : 32'hFFFF_FFFF, 32'(i + 1));
    chk({tag, "_img_count"}, 32'(img_q.size()), 32'(n_img));
    for (int i = 0; i < n_img; i++)
      chk($sformatf("%s_img_addr%0d", tag, i), (i < img_q.size()) ? img_q[i] : 32'hFFFF_FFFF, 32'(i));
    if (lat > 0) begin
      chk({tag, "_dv_count"}, 32'(dv_cyc.size()), 32'(n_img));
      for (int i = 0; i < n_img; i++)
        chk($sformatf("%s_dv_lag%0d", tag, i),
            (i < dv_cyc.size() && i < img_cyc.size()) ? 32'(dv_cyc[i] - img_cyc[i]) : 32'hFFFF_FFFF,
            32'(lat));
    end
    chk({tag, "_row_done_count"}, 32'(rd_idx.size()), 32'(n_rd));
    for (int i = 0; i < n_rd; i++)
      chk($sformatf("%s_row_done_at%0d", tag, i), (i < rd_idx.size()) ? 32'(rd_idx[i]) : 32'hFFFF_FFFF,
          32'(exp_rd[i]));
    chk({tag, "_compute_done_count"}, 32'(cd_cnt), 32'(cd_exp));
    if (busy_exp >= 0) chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(busy_exp));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1; start = 1'b0; run_en = 1'b1; abort = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs_lat1", outs_all(), 32'd0);
    sel = 1'b1;
    #1;
    chk("reset_outputs_lat3", outs_all(), 32'd0);
    idle_check("idle_after_reset", 3);

    // Nominal frame, BRAM_LAT=1.
    run_frame(1'b0, -1, -1, -1, -1);
    chk_frame("nominal", 8, 1, 20, 1, 2);
    idle_check("idle_after_nominal", 6);

    // Stall for 5 cycles at img_addr 2.
    run_frame(1'b0, 2, -1, -1, -1);
    chk_frame("stall", 8, 0, 25, 1, 2);
    idle_check("idle_after_stall", 6);

    // Abort at img_addr 5, then a fresh frame from address 0.
    run_frame(1'b0, -1, 5, -1, -1);
    chk_frame("abort", 6, 0, 9, 0, 1);
    idle_check("idle_after_abort", 6);
    run_frame(1'b0, -1, -1, -1, -1);
    chk_frame("after_abort", 8, 1, 20, 1, 2);
    idle_check("idle_after_abort_frame", 6);

    // start pulsed during STREAM must be ignored.
    run_frame(1'b0, -1, -1, 4, -1);
    chk_frame("start_ignored", 8, 1, 20, 1, 2);
    idle_check("idle_after_start_ignored", 6);

    // Reset at img_addr 4: quiet afterwards, then a nominal frame.
    run_frame(1'b0, -1, -1, -1, 4);
    chk_frame("reset_mid", 4, 0, 7, 0, 0);
    idle_check("idle_after_reset_mid", 6);
    run_frame(1'b0, -1, -1, -1, -1);
    chk_frame("after_reset", 8, 1, 20, 1, 2);
    idle_check("idle_after_reset_frame", 6);

    // Nominal frame, BRAM_LAT=3.
    run_frame(1'b1, -1, -1, -1, -1);
    chk_frame("lat3", 8, 3, 22, 1, 2);
    idle_check("idle_after_lat3", 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time bound on the whole run.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter IMG_ADDR_W, default 14, image bank address width.
REQ-002 Parameter KER_ADDR_W, default 2, kernel BRAM address width.
REQ-003 Parameter ROW_LEN, default 16, image words per row.
REQ-004 Parameter NUM_ROWS, default 8, rows per frame.
REQ-005 Parameter KER_ROWS, default 3, kernel rows to load.
REQ-006 Parameter BRAM_LAT, default 1, BRAM read latency in cycles (range 1-3).
REQ-007 Parameter DRAIN_CYC, default 8, systolic flush cycles after the last image read.
REQ-008 The block SHALL have one clock, `clk`, and an asynchronous, active-high reset, `rst`.
REQ-009 Port list:
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  frame start pulse
- run_en  in  1  global stall: 0 freezes all progress
- abort  in  1  synchronous abandon
- ker_en  out  1  kernel BRAM enable
- ker_addr  out  KER_ADDR_W  kernel BRAM address
- img_en  out  1  image bank enable, shared by all 8 banks
- img_addr  out  IMG_ADDR_W  image bank address, shared
- data_valid  out  1  bank data valid at tile input
- is_row_done  out  1  pulse, last column of a row valid
- is_compute_done  out  1  pulse, frame finished
- busy  out  1  not IDLE

Function
REQ-010 FSM states: IDLE, LOAD_K, STREAM, DRAIN, DONE.
REQ-011 IDLE: all outputs 0. start=1 moves the FSM to LOAD_K on the next edge. start SHALL be ignored in all other states.
REQ-012 LOAD_K: ker_en=1 and ker_addr=1..KER_ROWS, one per advancing cycle (address 0 reserved). After KER_ROWS cycles the FSM moves to STREAM.
REQ-013 STREAM: img_en=1 and img_addr runs linearly 0..ROW_LEN*NUM_ROWS-1, one per advancing cycle. The block keeps internal col/row counters. After the last address the FSM moves to DRAIN.
REQ-014 data_valid SHALL equal img_en delayed by exactly BRAM_LAT advancing cycles, using a shift pipeline.
REQ-015 is_row_done SHALL be a 1-cycle pulse, coincident with data_valid for col==ROW_LEN-1, delayed through the same pipeline.
REQ-016 DRAIN: the block counts DRAIN_CYC advancing cycles, then moves to DONE. The count starts only after the valid pipeline has emptied.
REQ-017 DONE: is_compute_done=1 for exactly one cycle, busy=1, then the FSM goes to IDLE.
REQ-018 busy=1 in every state except IDLE.
REQ-019 run_en=0 behaviour:
- freezes state, counters and the valid pipeline;
- forces ker_en, img_en, data_valid, is_row_done and is_compute_done to 0;
- holds addresses stable;
- resumes exactly where it stopped.
REQ-020 abort=1 in any non-IDLE state, regardless of run_en: the next state is IDLE, counters and pipeline are cleared, and no is_compute_done is produced. abort has priority over start.
REQ-021 Address counters SHALL never exceed their final value. No wrap occurs inside a frame. A frame SHALL always restart at address 0.
REQ-022 ROW_LEN*NUM_ROWS SHALL fit in IMG_ADDR_W. KER_ROWS < 2**KER_ADDR_W is checked by an elaboration assertion.

Reset
REQ-023 rst=1 SHALL asynchronously force:
- FSM to IDLE;
- all counters, the valid pipeline and all outputs to 0.
REQ-024 Reset asserted mid-frame SHALL produce no spurious pulse on release. After release the block SHALL wait for a new start.

Structure
REQ-025 The state enum and a default-constants set (ROW_LEN, NUM_ROWS, KER_ROWS, BRAM_LAT) SHALL live in a shared package, conv_pkg.
REQ-026 The BRAM_LAT delay line SHALL be one sub-module, valid_pipe: a parameterised shift register with enable and clear.

Verification (ROW_LEN=4, NUM_ROWS=2, KER_ROWS=3, BRAM_LAT=1, DRAIN_CYC=8)
REQ-027 Nominal frame: start pulse with run_en=1 -> the bench checks all of:
- ker_addr 1,2,3;
- img_addr 0..7;
- data_valid 8 cycles, one cycle behind img_en;
- is_row_done with addresses 3 and 7;
- is_compute_done once;
- busy for exactly 20 cycles.
REQ-028 Stall: run_en=0 for 5 cycles while img_addr=2 -> the bench checks:
- img_addr held at 2 with img_en=0;
- sequence resumes at 2;
- busy lasts 25 cycles.
REQ-029 Abort at img_addr=5 -> the bench checks:
- IDLE next cycle, all outputs 0;
- no is_compute_done;
- the next start restarts at ker_addr 1 and img_addr 0.
REQ-030 start pulsed during STREAM -> ignored; exactly one is_compute_done results.
REQ-031 rst asserted at img_addr=4 -> all outputs 0 immediately; no pulses after release; a new start gives a nominal frame.
REQ-032 BRAM_LAT=3 rerun of REQ-027 -> data_valid and is_row_done lag img_en by 3 cycles; busy lasts 22 cycles.
